sfx_scheduler: RTL and testbench

Sound-effect scheduler for the audio path: it arbitrates between game sound-effect requesters (shot, invader step, explosion, UFO) and feeds 16-bit PCM samples from the shared sample ROM to the I2S transmitter, one stereo word per transmitter frame. It sits between the game logic and the I2S transmitter. It runs on the same SCLK net as the transmitter and paces itself on the transmitter's Ready pulse.

---
 rtl/sfx_pkg.sv | 21 ++
 rtl/sfx_prio_enc.sv | 19 +
 rtl/sfx_scheduler.sv | 138 +++++++++++++
 tb/tb_sfx_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types and sound tables for the sound-effect scheduler.
package sfx_pkg;

  localparam int SFX_NUM    = 4;
  localparam int SFX_ADDR_W = 14;
  localparam int SFX_CNT_W  = SFX_ADDR_W + 1;

  localparam int SFX_SHOT    = 0;
  localparam int SFX_STEP    = 1;
  localparam int SFX_EXPLODE = 2;
  localparam int SFX_UFO     = 3;

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WAIT} sfx_state_t;

  // UFO sits at the top of the ROM and wraps back to address 0.
  localparam logic [SFX_ADDR_W-1:0] SFX_BASE [SFX_NUM] =
    '{14'h0000, 14'h0100, 14'h0200, 14'h3FFE};
  localparam logic [SFX_CNT_W-1:0]  SFX_LEN  [SFX_NUM] =
    '{15'd3, 15'd2, 15'd2, 15'd3};

endpackage

// File: rtl/sfx_prio_enc.sv
// Highest-index-wins priority encoder over the pending request bits.
module sfx_prio_enc #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates effect requests and feeds ROM samples to the I2S word.
// Optional build macro SFX_VOLUME_EN adds a volume[1:0] arithmetic-shift attenuator.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_SFX = SFX_NUM,
  parameter int ADDR_W  = SFX_ADDR_W
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       onOff,
`ifdef SFX_VOLUME_EN
  input  logic [1:0]                 volume,
`endif
  input  logic [NUM_SFX-1:0]         sfx_req,
  input  logic                       Ready,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [WIDTH-1:0]           rom_data,
  output logic [2*WIDTH-1:0]         Tx,
  output logic                       busy,
  output logic [$clog2(NUM_SFX)-1:0] active_id,
  output logic [NUM_SFX-1:0]         sfx_done
);

  localparam int ID_W = $clog2(NUM_SFX);

  sfx_state_t                  state, state_nxt;
  logic        [NUM_SFX-1:0]   pending, pend_clr;
  logic                        ready_q, ready_rise;
  logic        [ADDR_W-1:0]    ptr;
  logic        [ADDR_W:0]      cnt;
  logic        [ID_W-1:0]      id, sel_idx;
  logic                        sel_any, load, finish;
  logic        [2*WIDTH-1:0]   tx_q;
  logic        [NUM_SFX-1:0]   done_q;
  logic        [1:0]           vol;
  logic signed [WIDTH-1:0]     sample_s;

  function automatic logic signed [WIDTH-1:0] scale_sample(
    input logic signed [WIDTH-1:0] s,
    input logic [1:0]              sh
  );
    return s >>> sh;
  endfunction

`ifdef SFX_VOLUME_EN
  assign vol = volume;
`else
  assign vol = 2'd0;
`endif

  assign ready_rise = Ready & ~ready_q;
  assign sample_s   = scale_sample($signed(rom_data), vol);

  sfx_prio_enc #(.N(NUM_SFX), .IW(ID_W)) u_prio (
    .req (pending),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      pending <= '0;
      ready_q <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      id      <= '0;
      tx_q    <= '0;
      done_q  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= Ready;
      pending <= onOff ? ((pending & ~pend_clr) | sfx_req) : '0;
      done_q  <= '0;
      if (finish) done_q[id] <= 1'b1;
      if (load) begin
        ptr <= SFX_BASE[sel_idx];
        cnt <= SFX_LEN[sel_idx];
        id  <= sel_idx;
      end else if (state == CAPTURE) begin
        ptr <= ptr + ADDR_W'(1);
        cnt <= cnt - (ADDR_W+1)'(1);
      end
      // Tx is only rewritten in CAPTURE; any path back to IDLE silences it.
      if (!onOff || finish)
        tx_q <= '0;
      else if (state == CAPTURE)
        tx_q <= {sample_s, sample_s};
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    pend_clr  = '0;
    if (!onOff) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            load      = 1'b1;
            state_nxt = FETCH;
          end
        end
        FETCH:   state_nxt = CAPTURE;
        CAPTURE: state_nxt = WAIT;
        WAIT: begin
          if (ready_rise) begin
            state_nxt = FETCH;
            if (cnt == '0) begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end else if (sel_any && sel_idx >= id) begin
              // Equal index is a same-id restart, greater is a preemption.
              load = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (load) pend_clr[sel_idx] = 1'b1;
  end

  always_comb begin
    busy      = (state != IDLE);
    active_id = busy ? id : '0;
  end

  assign rom_addr = ptr;
  assign Tx       = tx_q;
  assign sfx_done = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with a registered sample-ROM model.
module tb_sfx_scheduler;
  import sfx_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        onOff = 1'b0;
  logic [3:0]  sfx_req = '0;
  logic        Ready = 1'b0;
  logic [13:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [31:0] Tx;
  logic        busy;
  logic [1:0]  active_id;
  logic [3:0]  sfx_done;
  logic        rom_force = 1'b0;
  logic        done_clr = 1'b0;
  logic [3:0]  done_seen = '0;
  int          checks = 0;
  int          failures = 0;
`ifdef SFX_VOLUME_EN
  logic [1:0]  volume = 2'd0;
`endif

  sfx_scheduler dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .onOff     (onOff),
`ifdef SFX_VOLUME_EN
    .volume    (volume),
`endif
    .sfx_req   (sfx_req),
    .Ready     (Ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .Tx        (Tx),
    .busy      (busy),
    .active_id (active_id),
    .sfx_done  (sfx_done)
  );

  always #5 Clock = ~Clock;

  // ROM contents: {addr[7:0]+1, 2'b00, addr[13:8]}; address 0..2 hold 0x0100/0x0200/0x0300.
  function automatic logic [15:0] rom_fn(input logic [13:0] a);
    logic [7:0] hi;
    hi = a[7:0] + 8'd1;
    return {hi, 2'b00, a[13:8]};
  endfunction

  always @(posedge Clock) begin
    rom_data  <= rom_force ? 16'h8000 : rom_fn(rom_addr);
    done_seen <= done_clr ? 4'b0000 : (done_seen | sfx_done);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_sound(input logic [3:0] mask);
    sfx_req = mask;
    tick();
    sfx_req = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic ready_pulse();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++; if (Tx !== 32'h0) begin failures++; $display("FAIL reset_tx got=%h exp=%h", Tx, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rom_addr !== 14'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", rom_addr); end
    checks++; if (active_id !== 2'd0 || sfx_done !== 4'b0) begin failures++; $display("FAIL reset_id_done got=%0d/%b exp=0/0000", active_id, sfx_done); end
    Reset = 1'b0;
    onOff = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    sfx_req = 4'b0001;
    tick();
    sfx_req = '0;
    tick();
    checks++; if (busy !== 1'b1 || rom_addr !== 14'h0000) begin failures++; $display("FAIL basic_fetch got=%b/%h exp=1/0000", busy, rom_addr); end
    tick();
    checks++; if (Tx !== 32'h0) begin failures++; $display("FAIL basic_early got=%h exp=%h", Tx, 32'h0); end
    tick();
    checks++; if (Tx !== 32'h0100_0100) begin failures++; $display("FAIL basic_s0 got=%h exp=%h", Tx, 32'h0100_0100); end
    tick();
    tick();
    checks++; if (Tx !== 32'h0100_0100) begin failures++; $display("FAIL basic_hold got=%h exp=%h", Tx, 32'h0100_0100); end
    ready_pulse();
    checks++; if (Tx !== 32'h0200_0200) begin failures++; $display("FAIL basic_s1 got=%h exp=%h", Tx, 32'h0200_0200); end
    ready_pulse();
    checks++; if (Tx !== 32'h0300_0300) begin failures++; $display("FAIL basic_s2 got=%h exp=%h", Tx, 32'h0300_0300); end
    Ready = 1'b1;
    tick();
    checks++; if (sfx_done !== 4'b0001) begin failures++; $display("FAIL basic_done got=%b exp=0001", sfx_done); end
    checks++; if (Tx !== 32'h0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%h/%b exp=0/0", Tx, busy); end
    Ready = 1'b0;
    tick();
    checks++; if (sfx_done !== 4'b0000) begin failures++; $display("FAIL basic_done_clr got=%b exp=0000", sfx_done); end
  endtask

  task automatic test_preempt();
    done_clr = 1'b1;
    tick();
    done_clr = 1'b0;
    start_sound(4'b0001);
    sfx_req = 4'b1000;
    tick();
    sfx_req = '0;
    checks++; if (active_id !== 2'd0 || Tx !== 32'h0100_0100) begin failures++; $display("FAIL pre_wait got=%0d/%h exp=0/01000100", active_id, Tx); end
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    checks++; if (active_id !== 2'd3) begin failures++; $display("FAIL pre_id got=%0d exp=3", active_id); end
    tick();
    tick();
    checks++; if (Tx !== 32'hFF3F_FF3F) begin failures++; $display("FAIL pre_s0 got=%h exp=%h", Tx, 32'hFF3F_FF3F); end
  endtask

  task automatic test_pending();
    sfx_req = 4'b0010;
    tick();
    sfx_req = '0;
    ready_pulse();
    checks++; if (Tx !== 32'h003F_003F || active_id !== 2'd3) begin failures++; $display("FAIL pend_s1 got=%h/%0d exp=003f003f/3", Tx, active_id); end
    ready_pulse();
    checks++; if (Tx !== 32'h0100_0100 || rom_addr !== 14'h0001) begin failures++; $display("FAIL pend_wrap got=%h/%h exp=01000100/0001", Tx, rom_addr); end
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    checks++; if (sfx_done !== 4'b1000 || busy !== 1'b0) begin failures++; $display("FAIL pend_done3 got=%b/%b exp=1000/0", sfx_done, busy); end
    checks++; if (done_seen[0] !== 1'b0) begin failures++; $display("FAIL pend_no_done0 got=%b exp=0", done_seen[0]); end
    tick();
    checks++; if (active_id !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL pend_id1 got=%0d/%b exp=1/1", active_id, busy); end
    tick();
    tick();
    checks++; if (Tx !== 32'h0101_0101) begin failures++; $display("FAIL pend_s1_0 got=%h exp=%h", Tx, 32'h0101_0101); end
    ready_pulse();
    checks++; if (Tx !== 32'h0201_0201) begin failures++; $display("FAIL pend_s1_1 got=%h exp=%h", Tx, 32'h0201_0201); end
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    checks++; if (sfx_done !== 4'b0010) begin failures++; $display("FAIL pend_done1 got=%b exp=0010", sfx_done); end
    tick();
  endtask

  task automatic test_restart();
    start_sound(4'b0100);
    checks++; if (Tx !== 32'h0102_0102) begin failures++; $display("FAIL rst2_s0 got=%h exp=%h", Tx, 32'h0102_0102); end
    ready_pulse();
    checks++; if (Tx !== 32'h0202_0202) begin failures++; $display("FAIL rst2_s1 got=%h exp=%h", Tx, 32'h0202_0202); end
    Ready = 1'b1;
    sfx_req = 4'b0100;
    tick();
    Ready = 1'b0;
    sfx_req = '0;
    checks++; if (sfx_done !== 4'b0100 || busy !== 1'b0) begin failures++; $display("FAIL rst2_done got=%b/%b exp=0100/0", sfx_done, busy); end
    tick();
    checks++; if (busy !== 1'b1 || active_id !== 2'd2 || rom_addr !== 14'h0200) begin failures++; $display("FAIL rst2_refetch got=%b/%0d/%h exp=1/2/0200", busy, active_id, rom_addr); end
    tick();
    tick();
    checks++; if (Tx !== 32'h0102_0102) begin failures++; $display("FAIL rst2_again got=%h exp=%h", Tx, 32'h0102_0102); end
    sfx_req = 4'b0100;
    tick();
    sfx_req = '0;
    ready_pulse();
    checks++; if (Tx !== 32'h0102_0102 || sfx_done !== 4'b0) begin failures++; $display("FAIL rst2_mid got=%h/%b exp=01020102/0000", Tx, sfx_done); end
  endtask

  task automatic test_onoff();
    done_clr = 1'b1;
    sfx_req = 4'b0001;
    tick();
    done_clr = 1'b0;
    sfx_req = '0;
    onOff = 1'b0;
    tick();
    checks++; if (Tx !== 32'h0 || busy !== 1'b0 || active_id !== 2'd0) begin failures++; $display("FAIL off_silence got=%h/%b/%0d exp=0/0/0", Tx, busy, active_id); end
    sfx_req = 4'b1000;
    tick();
    sfx_req = '0;
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    onOff = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b0 || Tx !== 32'h0) begin failures++; $display("FAIL off_pending got=%b/%h exp=0/0", busy, Tx); end
    checks++; if (done_seen !== 4'b0) begin failures++; $display("FAIL off_no_done got=%b exp=0000", done_seen); end
  endtask

  task automatic test_back_to_back();
    start_sound(4'b0011);
    checks++; if (active_id !== 2'd1 || Tx !== 32'h0101_0101) begin failures++; $display("FAIL b2b_first got=%0d/%h exp=1/01010101", active_id, Tx); end
    ready_pulse();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    checks++; if (sfx_done !== 4'b0010) begin failures++; $display("FAIL b2b_done got=%b exp=0010", sfx_done); end
    tick();
    tick();
    tick();
    checks++; if (active_id !== 2'd0 || Tx !== 32'h0100_0100) begin failures++; $display("FAIL b2b_second got=%0d/%h exp=0/01000100", active_id, Tx); end
  endtask

  task automatic test_reset_mid();
    sfx_req = 4'b0010;
    tick();
    sfx_req = '0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (Tx !== 32'h0 || busy !== 1'b0 || rom_addr !== 14'h0) begin failures++; $display("FAIL midrst got=%h/%b/%h exp=0/0/0", Tx, busy, rom_addr); end
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_pend got=%b exp=0", busy); end
  endtask

`ifdef SFX_VOLUME_EN
  task automatic test_volume();
    volume = 2'd2;
    rom_force = 1'b1;
    start_sound(4'b0001);
    checks++; if (Tx !== 32'hE000_E000) begin failures++; $display("FAIL vol_shift got=%h exp=%h", Tx, 32'hE000_E000); end
    rom_force = 1'b0;
    volume = 2'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_pending();
    test_restart();
    test_onoff();
    test_back_to_back();
    test_reset_mid();
`ifdef SFX_VOLUME_EN
    test_volume();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
